// File: rtl/alu_core.sv
// alu_core: single-cycle logic/arithmetic ALU plus an iterative shift-add
// multiplier (one multiplier bit per clock). While a multiply runs,
// ALU_RDY is low and new requests are dropped.
// Optional build macro: ALU_FLAGS_EN adds the registered ZERO and CARRY outputs.
module alu_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ACT,
  input  logic [3:0]              OP,
  input  logic [1:0]              MOVI,
  input  logic [DATA_WIDTH-1:0]   REG_A,
  input  logic [DATA_WIDTH-1:0]   REG_B,
  input  logic [DATA_WIDTH-1:0]   MEM,
  input  logic [DATA_WIDTH-1:0]   IMM,
  output logic                    ALU_RDY,
  output logic [2*DATA_WIDTH-1:0] EX_ALU,
  output logic                    EX_ALU_VLD
`ifdef ALU_FLAGS_EN
  ,
  output logic                    ZERO,
  output logic                    CARRY
`endif
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MULT = 4'd2;
  localparam logic [3:0] OP_SHL  = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_ROTL = 4'd5;
  localparam logic [3:0] OP_ROTR = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NAND = 4'd11;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_XNOR = 4'd13;
  localparam logic [3:0] OP_INC  = 4'd14;
  localparam logic [3:0] OP_DEC  = 4'd15;

  typedef enum logic {IDLE, MUL} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*W-1:0]      mcand_q, mcand_d;
  logic [W-1:0]        mplr_q, mplr_d;
  logic [2*W-1:0]      prod_q, prod_d;
  logic [2*W-1:0]      res_q, res_d;
  logic                vld_q, vld_d;
  logic [W-1:0]        opb;
  logic [2*W-1:0]      partial;

  // Single-cycle result; bit W carries the carry/borrow where relevant.
  function automatic logic [2*W-1:0] alu_single(input logic [3:0] op,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    logic [W:0] ext;
    ext = '0;
    case (op)
      OP_ADD:  ext = {1'b0, a} + {1'b0, b};
      OP_SUB:  ext = {1'b0, a} - {1'b0, b};
      OP_INC:  ext = {1'b0, a} + (W+1)'(1);
      OP_DEC:  ext = {1'b0, a} - (W+1)'(1);
      OP_SHL:  ext = {1'b0, a << 1};
      OP_SHR:  ext = {1'b0, a >> 1};
      OP_ROTL: ext = {1'b0, a[W-2:0], a[W-1]};
      OP_ROTR: ext = {1'b0, a[0], a[W-1:1]};
      OP_NOT:  ext = {1'b0, ~a};
      OP_AND:  ext = {1'b0, a & b};
      OP_OR:   ext = {1'b0, a | b};
      OP_XOR:  ext = {1'b0, a ^ b};
      OP_NAND: ext = {1'b0, ~(a & b)};
      OP_NOR:  ext = {1'b0, ~(a | b)};
      OP_XNOR: ext = {1'b0, ~(a ^ b)};
      default: ext = '0;
    endcase
    return {{(W-1){1'b0}}, ext};
  endfunction

  // Operand-B source select.
  always_comb begin
    opb = '0;
    case (MOVI)
      2'b00:   opb = REG_B;
      2'b01:   opb = MEM;
      2'b10:   opb = IMM;
      default: opb = '0;
    endcase
  end

  assign ALU_RDY    = (state_q == IDLE);
  assign EX_ALU     = res_q;
  assign EX_ALU_VLD = vld_q;

  // Next-state: accept in IDLE, one multiplier bit per cycle in MUL.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    prod_d  = prod_q;
    res_d   = res_q;
    vld_d   = 1'b0;
    partial = prod_q + (mplr_q[0] ? (mcand_q << cnt_q) : '0);
    case (state_q)
      IDLE: begin
        if (ACT) begin
          if (OP == OP_MULT) begin
            state_d = MUL;
            mcand_d = {{W{1'b0}}, REG_A};
            mplr_d  = opb;
            prod_d  = '0;
            cnt_d   = '0;
          end else begin
            res_d = alu_single(OP, REG_A, opb);
            vld_d = 1'b1;
          end
        end
      end
      MUL: begin
        prod_d = partial;
        mplr_d = mplr_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          res_d   = partial;
          vld_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, multiplier and result registers; reset aborts any multiply.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      prod_q  <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
    end
  end

`ifdef ALU_FLAGS_EN
  logic zero_q, carry_q, carry_sel;

  // Carry only means something for the single-cycle add/sub family.
  assign carry_sel = (state_q == IDLE) &&
                     ((OP == OP_ADD) || (OP == OP_SUB) || (OP == OP_INC) || (OP == OP_DEC));

  // Flags are captured with every new result so they track EX_ALU.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (vld_d) begin
      zero_q  <= (res_d == '0);
      carry_q <= carry_sel & res_d[W];
    end
  end

  assign ZERO  = zero_q;
  assign CARRY = carry_q;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core (DATA_WIDTH=8) with hand-computed expectations.
module tb_alu_core;

  localparam int W = 8;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           ACT = 1'b0;
  logic [3:0]     OP = '0;
  logic [1:0]     MOVI = '0;
  logic [W-1:0]   REG_A = '0, REG_B = '0, MEM = '0, IMM = '0;
  logic           ALU_RDY;
  logic [2*W-1:0] EX_ALU;
  logic           EX_ALU_VLD;
`ifdef ALU_FLAGS_EN
  logic           ZERO, CARRY;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  alu_core #(.DATA_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .ACT(ACT), .OP(OP), .MOVI(MOVI),
    .REG_A(REG_A), .REG_B(REG_B), .MEM(MEM), .IMM(IMM),
    .ALU_RDY(ALU_RDY), .EX_ALU(EX_ALU), .EX_ALU_VLD(EX_ALU_VLD)
`ifdef ALU_FLAGS_EN
    , .ZERO(ZERO), .CARRY(CARRY)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [1:0] movi, input logic [W-1:0] b);
    ACT = 1'b1; OP = op; REG_A = a; MOVI = movi;
    REG_B = 8'h11; MEM = 8'h22; IMM = 8'h33;
    case (movi)
      2'b00: REG_B = b;
      2'b01: MEM = b;
      2'b10: IMM = b;
      default: ;
    endcase
  endtask

  // Issue a MULT, check the 8 busy cycles and the single result pulse.
  task automatic do_mult(input string tag, input logic [W-1:0] a,
                         input logic [1:0] movi, input logic [W-1:0] b,
                         input logic [15:0] exp);
    set_req(4'd2, a, movi, b);
    step();
    ACT = 1'b0;
    for (int k = 1; k <= W; k++) begin
      chk({tag, "_busy_rdy"}, 32'(ALU_RDY), 32'd0);
      chk({tag, "_busy_vld"}, 32'(EX_ALU_VLD), 32'd0);
      step();
    end
    chk({tag, "_vld"}, 32'(EX_ALU_VLD), 32'd1);
    chk({tag, "_res"}, 32'(EX_ALU), 32'(exp));
    chk({tag, "_rdy"}, 32'(ALU_RDY), 32'd1);
    step();
    chk({tag, "_vld_end"}, 32'(EX_ALU_VLD), 32'd0);
  endtask

  logic [3:0]  v_op   [13] = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd7,
                               4'd3, 4'd4, 4'd5, 4'd6, 4'd1, 4'd8};
  logic [7:0]  v_a    [13] = '{8'hA0, 8'hFF, 8'hF0, 8'hF0, 8'hAA, 8'hFF, 8'h0F,
                               8'h81, 8'h81, 8'h81, 8'h81, 8'h05, 8'hF0};
  logic [1:0]  v_movi [13] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                               2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
  logic [7:0]  v_b    [13] = '{8'h05, 8'h0F, 8'h3C, 8'h0C, 8'h55, 8'h00, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00};
  logic [15:0] v_exp  [13] = '{16'h00A5, 16'h00F0, 16'h00CF, 16'h0003, 16'h0000,
                               16'h0100, 16'h00F0, 16'h0002, 16'h0040, 16'h0003,
                               16'h00C0, 16'h01FE, 16'h0000};

  initial begin
    // Reset state
    #3;
    chk("rst_rdy", 32'(ALU_RDY), 32'd1);
    chk("rst_res", 32'(EX_ALU), 32'd0);
    chk("rst_vld", 32'(EX_ALU_VLD), 32'd0);
    step();
    RST = 1'b0;
    step();

    // ADD with carry out
    set_req(4'd0, 8'hFF, 2'b00, 8'h01);
    step();
    ACT = 1'b0;
    chk("add_vld", 32'(EX_ALU_VLD), 32'd1);
    chk("add_res", 32'(EX_ALU), 32'h0100);
    step();
    chk("add_vld_end", 32'(EX_ALU_VLD), 32'd0);
    chk("add_hold", 32'(EX_ALU), 32'h0100);

    // SUB with B=0 and DEC wrap, back to back
    set_req(4'd1, 8'h00, 2'b11, 8'h00);
    step();
    chk("sub0_vld", 32'(EX_ALU_VLD), 32'd1);
    chk("sub0_res", 32'(EX_ALU), 32'h0000);
    set_req(4'd15, 8'h00, 2'b00, 8'h00);
    step();
    ACT = 1'b0;
    chk("dec_vld", 32'(EX_ALU_VLD), 32'd1);
    chk("dec_res", 32'(EX_ALU), 32'h01FF);

    // Back-to-back single-cycle ops across all operand sources
    for (int i = 0; i < 13; i++) begin
      set_req(v_op[i], v_a[i], v_movi[i], v_b[i]);
      step();
      chk($sformatf("vec%0d_vld", i), 32'(EX_ALU_VLD), 32'd1);
      chk($sformatf("vec%0d_res", i), 32'(EX_ALU), 32'(v_exp[i]));
    end
    ACT = 1'b0;
    step();

    // MULT 0xFF*0xFF with ACT held and other opcodes offered while busy
    set_req(4'd2, 8'hFF, 2'b10, 8'hFF);
    step();
    for (int k = 1; k <= W; k++) begin
      chk("mbusy_rdy", 32'(ALU_RDY), 32'd0);
      chk("mbusy_vld", 32'(EX_ALU_VLD), 32'd0);
      set_req((k % 2) ? 4'd0 : 4'd10, 8'h12, 2'b00, 8'h34);
      step();
    end
    chk("mff_vld", 32'(EX_ALU_VLD), 32'd1);
    chk("mff_res", 32'(EX_ALU), 32'hFE01);
    chk("mff_rdy", 32'(ALU_RDY), 32'd1);
    set_req(4'd8, 8'hF0, 2'b00, 8'h3C);
    step();
    ACT = 1'b0;
    chk("after_mul_vld", 32'(EX_ALU_VLD), 32'd1);
    chk("after_mul_res", 32'(EX_ALU), 32'h0030);
    step();
    chk("after_mul_vld_end", 32'(EX_ALU_VLD), 32'd0);

    // Further multiplies, including zero operands
    do_mult("m13x11", 8'h0D, 2'b01, 8'h0B, 16'h008F);
    do_mult("mA0", 8'h00, 2'b00, 8'h05, 16'h0000);
    do_mult("mB0", 8'hC3, 2'b11, 8'h00, 16'h0000);

    // Asynchronous reset in the 4th MULT cycle
    set_req(4'd2, 8'h07, 2'b10, 8'h09);
    step();
    ACT = 1'b0;
    step();
    step();
    step();
    #2;
    RST = 1'b1;
    #1;
    chk("arst_rdy", 32'(ALU_RDY), 32'd1);
    chk("arst_res", 32'(EX_ALU), 32'd0);
    #1;
    RST = 1'b0;
    begin
      int pulses = 0;
      for (int k = 0; k < 10; k++) begin
        step();
        if (EX_ALU_VLD) pulses++;
      end
      chk("arst_no_vld", 32'(pulses), 32'd0);
    end
    set_req(4'd8, 8'hF0, 2'b00, 8'h3C);
    step();
    ACT = 1'b0;
    chk("arst_and_vld", 32'(EX_ALU_VLD), 32'd1);
    chk("arst_and_res", 32'(EX_ALU), 32'h0030);

`ifdef ALU_FLAGS_EN
    // Flags
    set_req(4'd10, 8'h5A, 2'b00, 8'h5A);
    step();
    chk("flg_xor_res", 32'(EX_ALU), 32'h0000);
    chk("flg_xor_zero", 32'(ZERO), 32'd1);
    chk("flg_xor_carry", 32'(CARRY), 32'd0);
    set_req(4'd0, 8'h80, 2'b10, 8'h80);
    step();
    ACT = 1'b0;
    chk("flg_add_res", 32'(EX_ALU), 32'h0100);
    chk("flg_add_carry", 32'(CARRY), 32'd1);
    chk("flg_add_zero", 32'(ZERO), 32'd0);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
